// File: rtl/pe_result_writeback_pkg.sv
// rtl/pe_result_writeback_pkg.sv - shared types and constants for the PE result writeback stage
package pe_result_writeback_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_RESULTS_PER_FILTER = 43;

    function automatic int cnt_width(input int results);
        return $clog2(results + 1);
    endfunction

    localparam int CNT_W = cnt_width(DEF_RESULTS_PER_FILTER);

endpackage

// File: rtl/pe_result_writeback_if.sv
// rtl/pe_result_writeback_if.sv - PE result streams in, single memory write port out
interface pe_result_writeback_if #(
    parameter int NUM_FILTERS = 4,
    parameter int DATA_W      = 32,
    parameter int ADR_W       = 8
);
    logic [NUM_FILTERS-1:0]        pe_valid;
    logic [NUM_FILTERS*DATA_W-1:0] pe_data;
    logic [NUM_FILTERS-1:0]        pe_ready;
    logic                          mem_wr_en;
    logic [ADR_W-1:0]              mem_wr_adr;
    logic [DATA_W-1:0]             mem_wr_data;

    // master: PE array plus memory sink; slave: the writeback stage
    modport master (
        output pe_valid, pe_data,
        input  pe_ready, mem_wr_en, mem_wr_adr, mem_wr_data
    );

    modport slave (
        input  pe_valid, pe_data,
        output pe_ready, mem_wr_en, mem_wr_adr, mem_wr_data
    );
endinterface

// File: rtl/pe_result_writeback_rr_arbiter.sv
// rtl/pe_result_writeback_rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_vld
);
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = IDX_W'((int'(ptr) + k) % N);
            if (!grant_vld && req[idx]) begin
                grant_vld  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end
endmodule

// File: rtl/pe_result_writeback.sv
// rtl/pe_result_writeback.sv - captures per-filter PE results and writes them round-robin to memory
module pe_result_writeback
    import pe_result_writeback_pkg::*;
#(
    parameter int NUM_FILTERS        = 4,
    parameter int DATA_W             = 32,
    parameter int ADR_W              = 8,
    parameter int RESULTS_PER_FILTER = 43
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADR_W-1:0]          base_adr,
    input  logic [ADR_W-1:0]          stride,
    pe_result_writeback_if.slave      bus,
    output logic                      busy,
    output logic                      done,
    output logic                      ovf
);
    localparam int CW    = cnt_width(RESULTS_PER_FILTER);
    localparam int IDX_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(RESULTS_PER_FILTER);

    state_e                 state, state_nxt;
    logic [ADR_W-1:0]       base_q, stride_q;
    logic [NUM_FILTERS-1:0] slot_v;
    logic [DATA_W-1:0]      slot_d [NUM_FILTERS];
    logic [CW-1:0]          cnt    [NUM_FILTERS];
    logic [IDX_W-1:0]       rr_ptr;

    logic                   run_ok, all_done, drop;
    logic [NUM_FILTERS-1:0] full, accept, req, grant;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_vld;

    // a start pulse freezes the handshake so nothing is taken into a slot that is about to be flushed
    assign run_ok = (state == ST_RUN) && !start;
    assign req    = slot_v & {NUM_FILTERS{run_ok}};
    assign busy   = (state == ST_RUN);
    assign done   = (state == ST_DONE);

    rr_arbiter #(.N(NUM_FILTERS), .IDX_W(IDX_W)) u_arb (
        .req       (req),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // full: this filter already holds its whole quota (written + waiting), further words are overflow
    always_comb begin
        bus.pe_ready = '0;
        full         = '0;
        accept       = '0;
        drop         = 1'b0;
        all_done     = 1'b1;
        for (int i = 0; i < NUM_FILTERS; i++) begin
            full[i] = ({1'b0, cnt[i]} + (CW+1)'(slot_v[i])) >= (CW+1)'(RESULTS_PER_FILTER);
            if (cnt[i] != CNT_MAX || slot_v[i])
                all_done = 1'b0;
            bus.pe_ready[i] = run_ok & (full[i] | ~slot_v[i] | grant[i]);
            accept[i]       = bus.pe_valid[i] & bus.pe_ready[i] & ~full[i];
            if (bus.pe_valid[i] & bus.pe_ready[i] & full[i])
                drop = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_RUN;
        end else begin
            case (state)
                ST_RUN:  if (all_done) state_nxt = ST_DONE;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q          <= '0;
            stride_q        <= '0;
            slot_v          <= '0;
            rr_ptr          <= '0;
            ovf             <= 1'b0;
            bus.mem_wr_en   <= 1'b0;
            bus.mem_wr_adr  <= '0;
            bus.mem_wr_data <= '0;
            for (int i = 0; i < NUM_FILTERS; i++) begin
                slot_d[i] <= '0;
                cnt[i]    <= '0;
            end
        end else if (start) begin
            base_q        <= base_adr;
            stride_q      <= stride;
            slot_v        <= '0;
            rr_ptr        <= '0;
            ovf           <= 1'b0;
            bus.mem_wr_en <= 1'b0;
            for (int i = 0; i < NUM_FILTERS; i++)
                cnt[i] <= '0;
        end else begin
            bus.mem_wr_en <= grant_vld;
            if (grant_vld) begin
                bus.mem_wr_adr  <= base_q + ADR_W'(grant_idx) * stride_q + ADR_W'(cnt[grant_idx]);
                bus.mem_wr_data <= slot_d[grant_idx];
                cnt[grant_idx]  <= cnt[grant_idx] + CW'(1);
                rr_ptr          <= (grant_idx == IDX_W'(NUM_FILTERS-1)) ? '0 : grant_idx + IDX_W'(1);
            end
            for (int i = 0; i < NUM_FILTERS; i++) begin
                if (accept[i]) begin
                    slot_v[i] <= 1'b1;
                    slot_d[i] <= bus.pe_data[i*DATA_W +: DATA_W];
                end else if (grant[i]) begin
                    slot_v[i] <= 1'b0;
                end
            end
            if (drop)
                ovf <= 1'b1;
        end
    end
endmodule
